// File: rtl/metaball_pkg.sv
// metaball_pkg: shared types and constants for the metaball raster scanner.
//   q16_16_t     : Q16.16 fixed point coordinate / field value
//   rgb444_t     : framebuffer colour word
//   scan_state_t : scan controller states
//   sat_x2       : doubling with saturation at all ones (used for 2T / 4T)
package metaball_pkg;

   typedef logic [31:0] q16_16_t;
   typedef logic [11:0] rgb444_t;

   localparam rgb444_t COLOR_BLACK = 12'h000;
   localparam rgb444_t COLOR_WHITE = 12'hFFF;
   localparam rgb444_t SHADE_LUT [4] = '{12'h000, 12'h555, 12'hAAA, 12'hFFF};

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, SWAP} scan_state_t;

   function automatic q16_16_t sat_x2(input q16_16_t v);
      return v[31] ? '1 : {v[30:0], 1'b0};
   endfunction

endpackage

// File: rtl/metaball_field_sum.sv
// field_sum: per-channel sticky capture of metaball results, saturating
// N-way sum and colour quantiser.
//   clr      : clear sticky flags (scanner in ISSUE)
//   cap_en   : accept ball_vld / ball_out (scanner in WAIT)
//   mode     : 0 = binary, 1 = 4-level shaded
//   ball_vld : per-channel result valid
//   ball_out : per-channel Q16.16 value, channel i at [32i+31:32i]
//   all_vld  : every channel captured or arriving this cycle
//   colour   : colour of the captured sum (combinational from registers)
module field_sum
   import metaball_pkg::*;
#(
   parameter int      N_BALLS = 2,
   parameter q16_16_t THRESH  = 32'h0000_8000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  cap_en,
   input  logic                  mode,
   input  logic [N_BALLS-1:0]    ball_vld,
   input  logic [32*N_BALLS-1:0] ball_out,
   output logic                  all_vld,
   output rgb444_t               colour
);

   // enough headroom that N full-scale values cannot wrap before saturation
   localparam int ACC_W = 32 + $clog2(N_BALLS + 1);
   localparam q16_16_t T2 = sat_x2(THRESH);
   localparam q16_16_t T4 = sat_x2(T2);

   logic [N_BALLS-1:0]           sticky;
   logic [N_BALLS-1:0][31:0]     cap;
   logic [ACC_W-1:0]             acc;
   q16_16_t                      sum;
   logic [1:0]                   lvl;

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky <= '0;
         cap    <= '0;
      end else if (clr) begin
         sticky <= '0;
      end else if (cap_en) begin
         for (int i = 0; i < N_BALLS; i++) begin
            if (ball_vld[i]) begin
               sticky[i] <= 1'b1;
               cap[i]    <= ball_out[32*i +: 32];
            end
         end
      end
   end

   assign all_vld = &(sticky | ball_vld);

   always_comb begin
      acc = '0;
      for (int i = 0; i < N_BALLS; i++) acc = acc + ACC_W'(cap[i]);
   end

   assign sum = (|acc[ACC_W-1:32]) ? '1 : acc[31:0];

   always_comb begin
      lvl = 2'd0;
      if      (sum >= T4)     lvl = 2'd3;
      else if (sum >= T2)     lvl = 2'd2;
      else if (sum >= THRESH) lvl = 2'd1;
   end

   always_comb begin
      colour = COLOR_BLACK;
      if (mode) colour = SHADE_LUT[lvl];
      else if (sum >= THRESH) colour = COLOR_WHITE;
   end

endmodule

// File: rtl/metaball_scan.sv
// metaball_scan: raster scan controller for the metaball renderer.
// Steps a Q16.16 sample point over H_PIX x V_PIX, broadcasts it with px_stb,
// waits for every field channel, writes the quantised colour to the back
// framebuffer bank and requests a bank swap at the end of the frame.
//   start/mode         : frame kick-off and colour mode (latched at start)
//   px_stb/p_x/p_y     : sample point broadcast
//   ball_vld/ball_out  : per-channel field results
//   fb_we/fb_bank/fb_addr/fb_din : framebuffer write port
//   swap_req/swap_ack  : bank swap handshake with the display
//   busy/frame_cnt     : status
module metaball_scan
   import metaball_pkg::*;
#(
   parameter int      N_BALLS = 2,
   parameter int      H_PIX   = 32,
   parameter int      V_PIX   = 32,
   parameter q16_16_t STEP    = 32'h0000_8000,
   parameter q16_16_t THRESH  = 32'h0000_8000,
   parameter int      COLOR_W = 12,
   parameter int      ADDR_W  = $clog2(H_PIX*V_PIX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   output logic                  px_stb,
   output q16_16_t               p_x,
   output q16_16_t               p_y,
   input  logic [N_BALLS-1:0]    ball_vld,
   input  logic [32*N_BALLS-1:0] ball_out,
   output logic                  fb_we,
   output logic                  fb_bank,
   output logic [ADDR_W-1:0]     fb_addr,
   output logic [COLOR_W-1:0]    fb_din,
   output logic                  swap_req,
   input  logic                  swap_ack,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);

   scan_state_t       state;
   logic              mode_q;
   logic [15:0]       x;
   logic [15:0]       y;
   logic [ADDR_W-1:0] lin;
   logic              all_vld;
   rgb444_t           colour;

   field_sum #(.N_BALLS(N_BALLS), .THRESH(THRESH)) u_sum (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == ISSUE),
      .cap_en   (state == WAIT),
      .mode     (mode_q),
      .ball_vld (ball_vld),
      .ball_out (ball_out),
      .all_vld  (all_vld),
      .colour   (colour)
   );

   // lin tracks y*H_PIX + x directly, so no multiplier is needed
   assign fb_addr = lin;
   assign fb_din  = COLOR_W'(colour);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         x         <= '0;
         y         <= '0;
         lin       <= '0;
         p_x       <= '0;
         p_y       <= '0;
         px_stb    <= 1'b0;
         fb_we     <= 1'b0;
         fb_bank   <= 1'b0;
         swap_req  <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         px_stb <= 1'b0;
         fb_we  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mode_q <= mode;
               busy   <= 1'b1;
               px_stb <= 1'b1;
               state  <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (all_vld) begin
               fb_we <= 1'b1;
               state <= WRITE;
            end
            WRITE: begin
               if (x < 16'(H_PIX-1)) begin
                  x      <= x + 16'd1;
                  p_x    <= p_x + STEP;
                  lin    <= lin + ADDR_W'(1);
                  px_stb <= 1'b1;
                  state  <= ISSUE;
               end else if (y < 16'(V_PIX-1)) begin
                  x      <= '0;
                  p_x    <= '0;
                  y      <= y + 16'd1;
                  p_y    <= p_y + STEP;
                  lin    <= lin + ADDR_W'(1);
                  px_stb <= 1'b1;
                  state  <= ISSUE;
               end else begin
                  swap_req <= 1'b1;
                  state    <= SWAP;
               end
            end
            SWAP: if (swap_ack) begin
               swap_req  <= 1'b0;
               fb_bank   <= ~fb_bank;
               frame_cnt <= frame_cnt + 16'd1;
               x         <= '0;
               y         <= '0;
               lin       <= '0;
               p_x       <= '0;
               p_y       <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_metaball_scan.sv
// tb_metaball_scan: randomized self-checking bench for metaball_scan with a
// 4x2 grid and two field channels, checked against an arithmetic model.
module tb_metaball_scan;

   localparam int          NB   = 2;
   localparam int          HP   = 4;
   localparam int          VP   = 2;
   localparam logic [31:0] STEP = 32'h0000_8000;
   localparam logic [31:0] TH   = 32'h0000_8000;
   localparam int          AW   = $clog2(HP*VP);

   logic          clk, rst, start, mode, swap_ack;
   logic          px_stb, fb_we, fb_bank, swap_req, busy;
   logic [31:0]   p_x, p_y;
   logic [NB-1:0] ball_vld;
   logic [63:0]   ball_out;
   logic [AW-1:0] fb_addr;
   logic [11:0]   fb_din;
   logic [15:0]   frame_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_bank = 1'b0;
   int   exp_cnt  = 0;

   metaball_scan #(.N_BALLS(NB), .H_PIX(HP), .V_PIX(VP), .STEP(STEP),
                   .THRESH(TH), .COLOR_W(12)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .px_stb(px_stb), .p_x(p_x), .p_y(p_y),
      .ball_vld(ball_vld), .ball_out(ball_out),
      .fb_we(fb_we), .fb_bank(fb_bank), .fb_addr(fb_addr), .fb_din(fb_din),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // colour from the sum rules: saturate sum, thresholds T, 2T, 4T
   function automatic logic [11:0] ref_color(input logic m, input longint s);
      longint mx, t, t2, t4, ss;
      mx = 64'h0000_0000_FFFF_FFFF;
      t  = longint'(TH);
      ss = (s > mx) ? mx : s;
      t2 = (2*t > mx) ? mx : 2*t;
      t4 = (4*t > mx) ? mx : 4*t;
      if (!m) return (ss >= t) ? 12'hFFF : 12'h000;
      if (ss >= t4) return 12'hFFF;
      if (ss >= t2) return 12'hAAA;
      if (ss >= t)  return 12'h555;
      return 12'h000;
   endfunction

   task automatic chk_zero(input string pfx);
      chk({pfx, "_px_stb"},   px_stb,   0);
      chk({pfx, "_fb_we"},    fb_we,    0);
      chk({pfx, "_fb_addr"},  fb_addr,  0);
      chk({pfx, "_fb_din"},   fb_din,   0);
      chk({pfx, "_swap_req"}, swap_req, 0);
      chk({pfx, "_busy"},     busy,     0);
      chk({pfx, "_frame"},    frame_cnt, 0);
      chk({pfx, "_bank"},     fb_bank,  0);
      chk({pfx, "_p_x"},      p_x,      0);
      chk({pfx, "_p_y"},      p_y,      0);
   endtask

   // kind: 0 = 0x4000+0x4000, 1 = sum 0x7FFF, 2 = shade table,
   //       3 = random, 4 = skewed returns with stray vld/ack
   task automatic run_frame(input int kind, input logic m, input int ack_dly,
                            input int abort_at, input bit hold, input logic next_m);
      int n, d0, d1, dmax, bad, held;
      logic [31:0] v0, v1, v0b;
      bit refire, junk;
      longint s;
      mode  = m;
      start = 1'b1;
      n = 0;
      while (!px_stb && n < 20) begin step(); n++; end
      chk("start_px", px_stb, 1);
      start = hold;
      mode  = hold ? m : ~m;   // must be ignored after the latch
      for (int p = 0; p < HP*VP; p++) begin
         if (p > 0) begin
            n = 0;
            do begin step(); ball_vld = '0; n++; end while (!px_stb && n < 20);
            chk("px_stb", px_stb, 1);
         end
         chk("p_x", p_x, 32'(p % HP) * STEP);
         chk("p_y", p_y, 32'(p / HP) * STEP);
         d0 = 1; d1 = 1; refire = 0; junk = 0; v0b = 0;
         case (kind)
            0: begin v0 = 32'h4000; v1 = 32'h4000; end
            1: begin v0 = 32'h4000; v1 = 32'h3FFF; end
            2: case (p % 4)
                  0: begin v0 = 32'h8000;     v1 = 32'h0;     end
                  1: begin v0 = 32'h8000;     v1 = 32'h8000;  end
                  2: begin v0 = 32'h10000;    v1 = 32'h10000; end
                  default: begin v0 = 32'hFFFF_FFFF; v1 = 32'h10; end
               endcase
            4: begin
               d1 = 5; junk = 1;
               v0 = $urandom & 32'h3FFFF; v1 = $urandom & 32'h3FFFF;
            end
            default: begin
               d0 = $urandom_range(1, 6); d1 = $urandom_range(1, 6);
               v0 = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h8000_0000) : ($urandom & 32'h3FFFF);
               v1 = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h8000_0000) : ($urandom & 32'h3FFFF);
               v0b = $urandom & 32'h3FFFF;
               refire = (d0 < d1) && ($urandom_range(0, 1) == 1);
               junk = ($urandom_range(0, 1) == 1);
            end
         endcase
         dmax = (d0 > d1) ? d0 : d1;
         bad = 0;
         for (int c = 1; c <= dmax; c++) begin
            step();
            if (fb_we) bad++;
            ball_vld[0] = (c == d0) || (refire && c == dmax);
            ball_vld[1] = (c == d1);
            ball_out[31:0]  = (c == d0) ? v0 : (refire && c == dmax) ? v0b : $urandom;
            ball_out[63:32] = (c == d1) ? v1 : $urandom;
            swap_ack = (kind == 4) && (c == 2);
         end
         step();
         ball_vld = '0;
         swap_ack = 1'b0;
         ball_out = {$urandom, $urandom};
         chk("we_early", bad, 0);
         chk("fb_we", fb_we, 1);
         chk("fb_addr", fb_addr, p);
         s = longint'(refire ? v0b : v0) + longint'(v1);
         chk("fb_din", fb_din, ref_color(m, s));
         chk("bank_mid", fb_bank, exp_bank);
         if (junk) begin ball_vld = '1; ball_out = '1; end
         if (p == abort_at) begin
            rst = 1'b1;
            step();
            ball_vld = '0;
            start = 1'b0;
            chk_zero("rst_mid");
            rst = 1'b0;
            exp_bank = 1'b0;
            exp_cnt  = 0;
            step();
            chk("rst_no_we", fb_we, 0);
            return;
         end
      end
      step();
      ball_vld = '0;
      chk("swap_req", swap_req, 1);
      chk("swap_addr_we", fb_we, 0);
      held = 0; bad = 0;
      for (int k = 0; k < ack_dly; k++) begin
         if (swap_req) held++;
         if (fb_we || px_stb) bad++;
         step();
      end
      chk("swap_hold", held, ack_dly);
      chk("swap_quiet", bad, 0);
      chk("swap_req_pre", swap_req, 1);
      chk("bank_pre", fb_bank, exp_bank);
      if (hold) mode = next_m;
      swap_ack = 1'b1;
      step();
      swap_ack = 1'b0;
      exp_bank = ~exp_bank;
      exp_cnt++;
      chk("swap_drop", swap_req, 0);
      chk("bank", fb_bank, exp_bank);
      chk("frame_cnt", frame_cnt, 16'(exp_cnt));
      chk("idle_busy", busy, 0);
      if (hold) begin
         step();
         chk("retrig", px_stb, 1);
      end
   endtask

   logic modes [8];
   bit   holds [8];

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; swap_ack = 1'b0;
      ball_vld = '0; ball_out = '0;
      repeat (3) step();
      chk_zero("reset");
      rst = 1'b0;
      step();
      chk("idle_busy0", busy, 0);

      run_frame(0, 1'b0, 0,  -1, 0, 1'b0);
      run_frame(1, 1'b0, 2,  -1, 0, 1'b0);
      run_frame(2, 1'b1, 0,  -1, 0, 1'b0);
      run_frame(4, 1'b0, 10, -1, 0, 1'b0);
      run_frame(0, 1'b0, 0,  3,  0, 1'b0);
      run_frame(0, 1'b1, 1,  -1, 1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         modes[i] = 1'($urandom_range(0, 1));
         holds[i] = (i < 7) && ($urandom_range(0, 1) == 1);
      end
      modes[0] = 1'b0;   // previous frame handed over mode 0
      for (int i = 0; i < 8; i++)
         run_frame(3, modes[i], $urandom_range(0, 4), -1, holds[i],
                   (i < 7) ? modes[i+1] : 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
